// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared constants and types for the programmable-threshold FIFO.
//   DEFAULT_WIDTH / DEFAULT_DEPTH : default data width and entry count
//   fifo_flags_t                  : bundle of the combinational occupancy flags
// -----------------------------------------------------------------------------
package fifo_pkg;

   localparam int DEFAULT_WIDTH = 16;
   localparam int DEFAULT_DEPTH = 8;

   typedef struct packed {
      logic full;
      logic empty;
      logic almostfull;
      logic almostempty;
      logic prog_full;
      logic prog_empty;
   } fifo_flags_t;

endpackage : fifo_pkg

// File: rtl/fifo_mem.sv
// -----------------------------------------------------------------------------
// fifo_mem
// Simple dual-port storage array: one write port, one registered read port.
// Neither the array nor the read register is reset.
// Ports:
//   clk     in   clock, rising edge
//   wr_en   in   write strobe
//   wr_addr in   write address
//   wr_data in   write data
//   rd_en   in   read strobe; rd_data loads mem[rd_addr] on the edge
//   rd_addr in   read address
//   rd_data out  registered read data, holds when rd_en is low
// -----------------------------------------------------------------------------
module fifo_mem
   import fifo_pkg::*;
#(
   parameter int FIFO_WIDTH = DEFAULT_WIDTH,
   parameter int FIFO_DEPTH = DEFAULT_DEPTH,
   localparam int PTR_W     = $clog2(FIFO_DEPTH)
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [PTR_W-1:0]      wr_addr,
   input  logic [FIFO_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [PTR_W-1:0]      rd_addr,
   output logic [FIFO_WIDTH-1:0] rd_data
);

   logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [FIFO_WIDTH-1:0] rd_data_q;

   // Read-before-write: a read and write to the same address on one edge
   // returns the old contents, which the full pass-through case relies on.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data_q <= mem_q[rd_addr];
      end
   end

   assign rd_data = rd_data_q;

endmodule : fifo_mem

// File: rtl/prog_fifo.sv
// -----------------------------------------------------------------------------
// prog_fifo
// Synchronous FIFO with occupancy count, fixed and programmable flags.
// Depth need not be a power of two; pointers wrap explicitly at FIFO_DEPTH-1.
// Ports:
//   clk, rst_n            clock (rising edge) and asynchronous active-low reset
//   data_in, wr_en        write data / request
//   rd_en                 read request
//   flush                 synchronous clear, overrides wr_en/rd_en
//   prog_full_thr         prog_full  = count >= threshold (unregistered)
//   prog_empty_thr        prog_empty = count <= threshold (unregistered)
//   data_out              read data, one cycle after an accepted read
//   wr_ack/overflow/underflow  registered status of the previous edge
//   full, empty, almostfull, almostempty, prog_full, prog_empty, count
// -----------------------------------------------------------------------------
module prog_fifo
   import fifo_pkg::*;
#(
   parameter int FIFO_WIDTH = DEFAULT_WIDTH,
   parameter int FIFO_DEPTH = DEFAULT_DEPTH,
   localparam int CNT_W     = $clog2(FIFO_DEPTH + 1),
   localparam int PTR_W     = $clog2(FIFO_DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [FIFO_WIDTH-1:0] data_in,
   input  logic                  wr_en,
   input  logic                  rd_en,
   input  logic                  flush,
   input  logic [CNT_W-1:0]      prog_full_thr,
   input  logic [CNT_W-1:0]      prog_empty_thr,
   output logic [FIFO_WIDTH-1:0] data_out,
   output logic                  wr_ack,
   output logic                  overflow,
   output logic                  underflow,
   output logic                  full,
   output logic                  empty,
   output logic                  almostfull,
   output logic                  almostempty,
   output logic                  prog_full,
   output logic                  prog_empty,
   output logic [CNT_W-1:0]      count
);

   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  wr_ack_q, wr_ack_d;
   logic                  overflow_q, overflow_d;
   logic                  underflow_q, underflow_d;
   logic                  rd_seen_q, rd_seen_d;
   logic                  rd_ok;
   logic                  wr_ok;
   logic [FIFO_WIDTH-1:0] mem_rd_data;
   fifo_flags_t           flags;

   always_comb begin
      rd_ok = rd_en && !flush && (count_q != '0);
      // A write into a full FIFO is allowed when a read frees a slot on the same edge.
      wr_ok = wr_en && !flush && ((count_q < CNT_FULL) || rd_ok);

      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      rd_seen_d   = rd_seen_q || rd_ok;
      wr_ack_d    = wr_ok;
      overflow_d  = wr_en && !wr_ok && !flush;
      underflow_d = rd_en && !rd_ok && !flush;

      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (wr_ok) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
         end
         if (rd_ok) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
         end
         case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         wr_ack_q    <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
         rd_seen_q   <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         wr_ack_q    <= wr_ack_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
         rd_seen_q   <= rd_seen_d;
      end
   end

   fifo_mem #(
      .FIFO_WIDTH (FIFO_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_mem (
      .clk     (clk),
      .wr_en   (wr_ok),
      .wr_addr (wr_ptr_q),
      .wr_data (data_in),
      .rd_en   (rd_ok),
      .rd_addr (rd_ptr_q),
      .rd_data (mem_rd_data)
   );

   // The storage read register has no reset, so data_out is forced to zero
   // until the first accepted read after reset; after that it follows the
   // read register, which holds across flush and idle cycles.
   assign data_out = rd_seen_q ? mem_rd_data : '0;

   always_comb begin
      flags.full        = (count_q == CNT_FULL);
      flags.empty       = (count_q == '0);
      flags.almostfull  = (count_q == CNT_W'(FIFO_DEPTH - 1));
      flags.almostempty = (count_q == CNT_W'(1));
      flags.prog_full   = (count_q >= prog_full_thr);
      flags.prog_empty  = (count_q <= prog_empty_thr);
   end

   assign full        = flags.full;
   assign empty       = flags.empty;
   assign almostfull  = flags.almostfull;
   assign almostempty = flags.almostempty;
   assign prog_full   = flags.prog_full;
   assign prog_empty  = flags.prog_empty;
   assign count       = count_q;
   assign wr_ack      = wr_ack_q;
   assign overflow    = overflow_q;
   assign underflow   = underflow_q;

`ifndef SYNTHESIS
   a_wr_ack: assert property (@(posedge clk) disable iff (!rst_n)
      1'b1 |=> (wr_ack_q == $past(wr_ok)));
   a_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      1'b1 |=> (overflow_q == $past(wr_en && !wr_ok && !flush)));
   a_underflow: assert property (@(posedge clk) disable iff (!rst_n)
      1'b1 |=> (underflow_q == $past(rd_en && !rd_ok && !flush)));
   a_count_inc: assert property (@(posedge clk) disable iff (!rst_n)
      (wr_ok && !rd_ok) |=> (count_q == $past(count_q) + CNT_W'(1)));
   a_count_dec: assert property (@(posedge clk) disable iff (!rst_n)
      (rd_ok && !wr_ok) |=> (count_q == $past(count_q) - CNT_W'(1)));
   a_count_flush: assert property (@(posedge clk) disable iff (!rst_n)
      flush |=> (count_q == '0));
   a_count_max: assert property (@(posedge clk) disable iff (!rst_n)
      count_q <= CNT_FULL);
   a_flag_decode: assert property (@(posedge clk) disable iff (!rst_n)
      (flags.full == (count_q == CNT_FULL)) && (flags.empty == (count_q == '0)));
`endif

endmodule : prog_fifo

// File: tb/tb_prog_fifo.sv
module tb_prog_fifo;

   localparam int W  = 16;
   localparam int D  = 6;
   localparam int CW = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [W-1:0]  data_in;
   logic          wr_en;
   logic          rd_en;
   logic          flush;
   logic [CW-1:0] prog_full_thr;
   logic [CW-1:0] prog_empty_thr;
   logic [W-1:0]  data_out;
   logic          wr_ack;
   logic          overflow;
   logic          underflow;
   logic          full;
   logic          empty;
   logic          almostfull;
   logic          almostempty;
   logic          prog_full;
   logic          prog_empty;
   logic [CW-1:0] count;

   int pass_cnt  = 0;
   int total_cnt = 0;

   prog_fifo #(
      .FIFO_WIDTH (W),
      .FIFO_DEPTH (D)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .data_in        (data_in),
      .wr_en          (wr_en),
      .rd_en          (rd_en),
      .flush          (flush),
      .prog_full_thr  (prog_full_thr),
      .prog_empty_thr (prog_empty_thr),
      .data_out       (data_out),
      .wr_ack         (wr_ack),
      .overflow       (overflow),
      .underflow      (underflow),
      .full           (full),
      .empty          (empty),
      .almostfull     (almostfull),
      .almostempty    (almostempty),
      .prog_full      (prog_full),
      .prog_empty     (prog_empty),
      .count          (count)
   );

   always #5 clk = ~clk;

   // Advance one rising edge and settle just after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; data_in = '0; wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0;
      prog_full_thr = 3'd4; prog_empty_thr = 3'd1;
      step(); step();
      total_cnt++; if (count !== 3'd0) $display("FAIL reset_count: got %0d expected 0", count); else pass_cnt++;
      total_cnt++; if (empty !== 1'b1) $display("FAIL reset_empty: got %b expected 1", empty); else pass_cnt++;
      total_cnt++; if (full !== 1'b0) $display("FAIL reset_full: got %b expected 0", full); else pass_cnt++;
      total_cnt++; if (data_out !== 16'h0000) $display("FAIL reset_data_out: got %h expected 0000", data_out); else pass_cnt++;
      total_cnt++; if (wr_ack !== 1'b0) $display("FAIL reset_wr_ack: got %b expected 0", wr_ack); else pass_cnt++;
      total_cnt++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b expected 0", overflow); else pass_cnt++;
      total_cnt++; if (underflow !== 1'b0) $display("FAIL reset_underflow: got %b expected 0", underflow); else pass_cnt++;
      #3 rst_n = 1'b1;
      step();
      $display("reset released, count=%0d", count);
   endtask

   task automatic test_fill();
      for (int i = 1; i <= 6; i++) begin
         wr_en = 1'b1; data_in = 16'(i);
         step();
         $display("write %h -> wr_ack=%b count=%0d", data_in, wr_ack, count);
         total_cnt++; if (wr_ack !== 1'b1) $display("FAIL fill_wr_ack[%0d]: got %b expected 1", i, wr_ack); else pass_cnt++;
         total_cnt++; if (count !== 3'(i)) $display("FAIL fill_count[%0d]: got %0d expected %0d", i, count, i); else pass_cnt++;
      end
      total_cnt++; if (full !== 1'b1) $display("FAIL fill_full: got %b expected 1", full); else pass_cnt++;
      data_in = 16'h0007;
      step();
      $display("write %h (7th) -> overflow=%b wr_ack=%b", data_in, overflow, wr_ack);
      total_cnt++; if (overflow !== 1'b1) $display("FAIL fill_overflow: got %b expected 1", overflow); else pass_cnt++;
      total_cnt++; if (wr_ack !== 1'b0) $display("FAIL fill_ovf_wr_ack: got %b expected 0", wr_ack); else pass_cnt++;
      total_cnt++; if (count !== 3'd6) $display("FAIL fill_ovf_count: got %0d expected 6", count); else pass_cnt++;
      wr_en = 1'b0;
   endtask

   task automatic test_drain();
      rd_en = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         step();
         $display("read -> data_out=%h count=%0d", data_out, count);
         total_cnt++; if (data_out !== 16'(i)) $display("FAIL drain_data[%0d]: got %h expected %h", i, data_out, 16'(i)); else pass_cnt++;
         total_cnt++; if (count !== 3'(6 - i)) $display("FAIL drain_count[%0d]: got %0d expected %0d", i, count, 6 - i); else pass_cnt++;
      end
      total_cnt++; if (empty !== 1'b1) $display("FAIL drain_empty: got %b expected 1", empty); else pass_cnt++;
      step();
      $display("read (7th) -> underflow=%b", underflow);
      total_cnt++; if (underflow !== 1'b1) $display("FAIL drain_underflow: got %b expected 1", underflow); else pass_cnt++;
      total_cnt++; if (data_out !== 16'h0006) $display("FAIL drain_hold: got %h expected 0006", data_out); else pass_cnt++;
      rd_en = 1'b0;
   endtask

   task automatic test_wrap();
      int rd_n;
      int exp_cnt;
      rd_n = 0;
      // 3 writes to prime, 17 write+read cycles, then 3 reads to drain.
      for (int c = 0; c < 23; c++) begin
         wr_en = (c < 20); rd_en = (c >= 3);
         data_in = 16'h0100 + 16'(c);
         exp_cnt = (c < 3) ? c + 1 : ((c < 20) ? 3 : 22 - c);
         step();
         if (rd_en) begin
            $display("wrap cycle %0d read -> %h", c, data_out);
            total_cnt++; if (data_out !== 16'h0100 + 16'(rd_n)) $display("FAIL wrap_data[%0d]: got %h expected %h", rd_n, data_out, 16'h0100 + 16'(rd_n)); else pass_cnt++;
            rd_n++;
         end
         total_cnt++; if (count !== 3'(exp_cnt)) $display("FAIL wrap_count[%0d]: got %0d expected %0d", c, count, exp_cnt); else pass_cnt++;
         total_cnt++; if (dut.wr_ptr_q > 3'd5 || dut.rd_ptr_q > 3'd5) $display("FAIL wrap_ptr[%0d]: got wr=%0d rd=%0d expected both below 6", c, dut.wr_ptr_q, dut.rd_ptr_q); else pass_cnt++;
      end
      wr_en = 1'b0; rd_en = 1'b0;
   endtask

   task automatic test_simultaneous();
      wr_en = 1'b1; rd_en = 1'b1; data_in = 16'hAAAA;
      step();
      $display("wr+rd at empty -> count=%0d underflow=%b wr_ack=%b", count, underflow, wr_ack);
      total_cnt++; if (count !== 3'd1) $display("FAIL simul_empty_count: got %0d expected 1", count); else pass_cnt++;
      total_cnt++; if (underflow !== 1'b1) $display("FAIL simul_empty_underflow: got %b expected 1", underflow); else pass_cnt++;
      total_cnt++; if (wr_ack !== 1'b1) $display("FAIL simul_empty_wr_ack: got %b expected 1", wr_ack); else pass_cnt++;
      rd_en = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         data_in = 16'hBB00 + 16'(i);
         step();
      end
      total_cnt++; if (full !== 1'b1) $display("FAIL simul_prefill_full: got %b expected 1", full); else pass_cnt++;
      rd_en = 1'b1; data_in = 16'hCCCC;
      step();
      $display("wr+rd at full -> count=%0d overflow=%b data_out=%h", count, overflow, data_out);
      total_cnt++; if (count !== 3'd6) $display("FAIL simul_full_count: got %0d expected 6", count); else pass_cnt++;
      total_cnt++; if (overflow !== 1'b0) $display("FAIL simul_full_overflow: got %b expected 0", overflow); else pass_cnt++;
      total_cnt++; if (wr_ack !== 1'b1) $display("FAIL simul_full_wr_ack: got %b expected 1", wr_ack); else pass_cnt++;
      total_cnt++; if (data_out !== 16'hAAAA) $display("FAIL simul_full_data: got %h expected aaaa", data_out); else pass_cnt++;
      wr_en = 1'b0; rd_en = 1'b0;
   endtask

   task automatic test_prog_thresholds();
      bit pe_tab [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      bit pf_tab [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      prog_full_thr = 3'd4; prog_empty_thr = 3'd1;
      flush = 1'b1;
      step();
      flush = 1'b0;
      total_cnt++; if (count !== 3'd0) $display("FAIL prog_flush_count: got %0d expected 0", count); else pass_cnt++;
      total_cnt++; if (prog_empty !== pe_tab[0]) $display("FAIL prog_empty[0]: got %b expected %b", prog_empty, pe_tab[0]); else pass_cnt++;
      total_cnt++; if (prog_full !== pf_tab[0]) $display("FAIL prog_full[0]: got %b expected %b", prog_full, pf_tab[0]); else pass_cnt++;
      for (int c = 1; c <= 6; c++) begin
         wr_en = 1'b1; data_in = 16'h0D00 + 16'(c);
         step();
         $display("prog count=%0d prog_empty=%b prog_full=%b", count, prog_empty, prog_full);
         total_cnt++; if (prog_empty !== pe_tab[c]) $display("FAIL prog_empty[%0d]: got %b expected %b", c, prog_empty, pe_tab[c]); else pass_cnt++;
         total_cnt++; if (prog_full !== pf_tab[c]) $display("FAIL prog_full[%0d]: got %b expected %b", c, prog_full, pf_tab[c]); else pass_cnt++;
         if (c == 4) begin
            prog_full_thr = 3'd5;
            #1;
            total_cnt++; if (prog_full !== 1'b0) $display("FAIL prog_thr5_at4: got %b expected 0", prog_full); else pass_cnt++;
            prog_full_thr = 3'd4;
            #1;
            total_cnt++; if (prog_full !== 1'b1) $display("FAIL prog_thr4_at4: got %b expected 1", prog_full); else pass_cnt++;
         end
      end
      wr_en = 1'b0;
   endtask

   task automatic test_flush();
      rd_en = 1'b1;
      repeat (3) step();
      rd_en = 1'b0;
      total_cnt++; if (count !== 3'd3) $display("FAIL flush_pre_count: got %0d expected 3", count); else pass_cnt++;
      total_cnt++; if (data_out !== 16'h0D03) $display("FAIL flush_pre_data: got %h expected 0d03", data_out); else pass_cnt++;
      flush = 1'b1; wr_en = 1'b1; data_in = 16'hFFFF;
      step();
      flush = 1'b0; wr_en = 1'b0;
      $display("flush -> count=%0d wr_ack=%b data_out=%h", count, wr_ack, data_out);
      total_cnt++; if (count !== 3'd0) $display("FAIL flush_count: got %0d expected 0", count); else pass_cnt++;
      total_cnt++; if (wr_ack !== 1'b0) $display("FAIL flush_wr_ack: got %b expected 0", wr_ack); else pass_cnt++;
      total_cnt++; if (overflow !== 1'b0) $display("FAIL flush_overflow: got %b expected 0", overflow); else pass_cnt++;
      total_cnt++; if (data_out !== 16'h0D03) $display("FAIL flush_data_hold: got %h expected 0d03", data_out); else pass_cnt++;
      total_cnt++; if (empty !== 1'b1) $display("FAIL flush_empty: got %b expected 1", empty); else pass_cnt++;
   endtask

   task automatic test_reset_midburst();
      wr_en = 1'b1;
      data_in = 16'h5001; step();
      data_in = 16'h5002; step();
      data_in = 16'h5003; step();
      rd_en = 1'b1; data_in = 16'h5004; step();
      total_cnt++; if (count !== 3'd3) $display("FAIL burst_count: got %0d expected 3", count); else pass_cnt++;
      total_cnt++; if (data_out !== 16'h5001) $display("FAIL burst_data: got %h expected 5001", data_out); else pass_cnt++;
      #3 rst_n = 1'b0;
      #1;
      $display("async reset mid-burst -> count=%0d data_out=%h", count, data_out);
      total_cnt++; if (count !== 3'd0) $display("FAIL midrst_count: got %0d expected 0", count); else pass_cnt++;
      total_cnt++; if (empty !== 1'b1) $display("FAIL midrst_empty: got %b expected 1", empty); else pass_cnt++;
      total_cnt++; if (full !== 1'b0) $display("FAIL midrst_full: got %b expected 0", full); else pass_cnt++;
      total_cnt++; if (data_out !== 16'h0000) $display("FAIL midrst_data_out: got %h expected 0000", data_out); else pass_cnt++;
      total_cnt++; if (wr_ack !== 1'b0) $display("FAIL midrst_wr_ack: got %b expected 0", wr_ack); else pass_cnt++;
      total_cnt++; if (overflow !== 1'b0 || underflow !== 1'b0) $display("FAIL midrst_ovf_unf: got %b%b expected 00", overflow, underflow); else pass_cnt++;
      wr_en = 1'b0; rd_en = 1'b0;
      step();
      #3 rst_n = 1'b1;
      wr_en = 1'b1; rd_en = 1'b1; data_in = 16'h6001;
      step();
      $display("post-reset wr+rd -> count=%0d underflow=%b", count, underflow);
      total_cnt++; if (count !== 3'd1) $display("FAIL postrst_count: got %0d expected 1", count); else pass_cnt++;
      total_cnt++; if (underflow !== 1'b1) $display("FAIL postrst_underflow: got %b expected 1", underflow); else pass_cnt++;
      wr_en = 1'b0;
      step();
      total_cnt++; if (data_out !== 16'h6001) $display("FAIL postrst_data: got %h expected 6001", data_out); else pass_cnt++;
      total_cnt++; if (empty !== 1'b1) $display("FAIL postrst_empty: got %b expected 1", empty); else pass_cnt++;
      rd_en = 1'b0;
   endtask

   initial begin
      test_reset();
      test_fill();
      test_drain();
      test_wrap();
      test_simultaneous();
      test_prog_thresholds();
      test_flush();
      test_reset_midburst();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule : tb_prog_fifo

// File: doc/prog_fifo.md
PROG_FIFO -- requirements
Module: prog_fifo

Interface
REQ-001 SHALL have parameter FIFO_WIDTH, default 16: data width in bits, minimum 1.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8: number of entries, minimum 2, need not be a power of two.
REQ-003 SHALL derive CNT_W = $clog2(FIFO_DEPTH+1) and PTR_W = $clog2(FIFO_DEPTH); these are not overridable.
REQ-004 SHALL have ports, listed as name, direction, width, meaning:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- data_in  in  FIFO_WIDTH  write data.
- wr_en  in  1  write request.
- rd_en  in  1  read request.
- flush  in  1  synchronous clear.
- prog_full_thr  in  CNT_W  programmable-full threshold.
- prog_empty_thr  in  CNT_W  programmable-empty threshold.
- data_out  out  FIFO_WIDTH  registered read data.
- wr_ack  out  1  write accepted last cycle.
- overflow  out  1  write rejected last cycle.
- underflow  out  1  read rejected last cycle.
- full, empty, almostfull, almostempty  out  1  occupancy flags.
- prog_full, prog_empty  out  1  threshold flags.
- count  out  CNT_W  current occupancy.

Function
REQ-005 SHALL accept a read (rd_ok) when rd_en=1, flush=0 and count!=0.
REQ-006 SHALL accept a write (wr_ok) when wr_en=1, flush=0, and either count<FIFO_DEPTH or rd_ok=1 in the same cycle (full pass-through).
REQ-007 On wr_ok, SHALL store data_in at wr_ptr and advance wr_ptr, wrapping from FIFO_DEPTH-1 to 0.
REQ-008 On rd_ok, SHALL register mem[rd_ptr] into data_out on that edge (1-cycle latency) and advance rd_ptr with the same wrap rule; otherwise data_out SHALL hold.
REQ-009 count SHALL update on each edge: +1 on wr_ok only, -1 on rd_ok only, unchanged when both or neither occur; count SHALL never exceed FIFO_DEPTH or go below 0.
REQ-010 wr_ack, overflow and underflow SHALL be registered: wr_ack=wr_ok, overflow=wr_en&&!wr_ok&&!flush, underflow=rd_en&&!rd_ok&&!flush, all sampled on the previous edge.
REQ-011 When empty and wr_en=rd_en=1: the write SHALL be accepted, the read rejected (underflow=1 next cycle), and count SHALL become 1.
REQ-012 When full and wr_en=rd_en=1: both SHALL be accepted, count SHALL stay FIFO_DEPTH, and overflow SHALL be 0.
REQ-013 Combinational flags SHALL be:
- full = (count==FIFO_DEPTH)
- empty = (count==0)
- almostfull = (count==FIFO_DEPTH-1)
- almostempty = (count==1)
- prog_full = (count>=prog_full_thr)
- prog_empty = (count<=prog_empty_thr)
REQ-014 flush=1 SHALL take priority over wr_en/rd_en: on that edge count, wr_ptr and rd_ptr SHALL go to 0, wr_ack, overflow and underflow SHALL go to 0, and data_out and memory contents SHALL hold.
REQ-015 Threshold inputs SHALL be usable without registering, may change on any cycle, and SHALL take effect on the flags combinationally.

Reset
REQ-016 While rst_n=0, asynchronously: count=0, wr_ptr=0, rd_ptr=0, data_out=0, wr_ack=0, overflow=0, underflow=0; hence empty=1, full=0.
REQ-017 Memory contents SHALL NOT be reset.
REQ-018 Reset asserted mid-operation SHALL discard all stored entries; the first edge after rst_n rises SHALL behave as from an empty FIFO.

Structure
REQ-019 Package fifo_pkg SHALL hold the default width and depth constants and a typedef for the occupancy-flag bundle.
REQ-020 Storage SHALL be a sub-module fifo_mem: one write port, one synchronous read port, no reset, parametrised by FIFO_WIDTH and FIFO_DEPTH.
REQ-021 Protocol assertions (write ack, overflow, underflow, count step, flag decode) SHALL be embedded under an SVA guard and SHALL be disabled during reset.

Verification
REQ-022 SHALL cover the following directed scenarios, with FIFO_DEPTH=6 and FIFO_WIDTH=16:
- Write 0x0001..0x0006 -> wr_ack high on each following cycle; full=1, count=6; a 7th write gives overflow=1, wr_ack=0.
- From full, read 6 times -> data_out is 0x0001..0x0006 in order, each 1 cycle after rd_en; then empty=1; a 7th read gives underflow=1.
- Run 20 writes interleaved with reads to cross the non-power-of-two wrap -> data order is preserved and no pointer reaches 6.
- Simultaneous wr_en and rd_en at full and at empty -> count stays 6 at full with overflow=0; count becomes 1 at empty with underflow=1.
- prog_full_thr=4, prog_empty_thr=1, fill from 0 to 6 -> prog_empty high at counts 0-1, prog_full high at counts 4-6; changing prog_full_thr to 5 at count 4 deasserts prog_full in the same cycle.
- Flush at count=3 with wr_en=1 -> count=0 and wr_ack=0 next cycle, data_out unchanged; assert rst_n=0 mid-burst -> all outputs take their reset values immediately.
